// File: rtl/nes_controller_reader.sv
// Latch/shift-clock generator and sampler for NES/SNES pads on a shared bus.
// Publishes a per-frame button vector with pressed/released edge flags.
module nes_controller_reader #(
   parameter int CLK_HZ      = 50000000,
   parameter int NUM_PADS    = 1,
   parameter int BITS        = 8,
   parameter int HALF_CYCLES = 300,
   parameter int POLL_CYCLES = 833333
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     poll_now,
   input  logic [NUM_PADS-1:0]      nes_data,
   output logic                     nes_latch,
   output logic                     nes_clock,
   output logic [NUM_PADS*BITS-1:0] buttons,
   output logic [NUM_PADS*BITS-1:0] pressed,
   output logic [NUM_PADS*BITS-1:0] released,
   output logic                     valid,
   output logic                     busy
);

   localparam int W  = NUM_PADS * BITS;
   localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;
   localparam int CW = $clog2(2 * HALF_CYCLES);
   localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

   localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);
   localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(BITS - 1);

   // A nonsensical clock or a poll period shorter than a frame disables auto polling
   localparam bit AUTO_OK = (CLK_HZ > 0) &&
                            (POLL_CYCLES > 2 * HALF_CYCLES * BITS);

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      CLK_HI,
      CLK_LO,
      DONE
   } state_t;

   state_t              state, state_n;
   logic [NUM_PADS-1:0] sync1, sync2;
   logic [PW-1:0]       poll_cnt;
   logic [CW-1:0]       cnt, cnt_n;
   logic [IW-1:0]       idx, idx_n;
   logic [W-1:0]        shift_q, shift_n;
   logic                sample;
   logic                tick;
   logic                start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= nes_data;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         poll_cnt <= '0;
      else if (!enable || poll_cnt == POLL_LAST)
         poll_cnt <= '0;
      else
         poll_cnt <= poll_cnt + PW'(1);
   end

   assign tick  = enable && AUTO_OK && (poll_cnt == POLL_LAST);
   assign start = tick || poll_now;

   always_comb begin
      state_n = state;
      cnt_n   = cnt + CW'(1);
      idx_n   = idx;
      sample  = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            idx_n = '0;
            if (start)
               state_n = LATCH;
         end
         LATCH: begin
            if (cnt == LATCH_LAST) begin
               sample = 1'b1;
               cnt_n  = '0;
               if (BITS == 1) begin
                  state_n = DONE;
               end else begin
                  state_n = CLK_HI;
                  idx_n   = IW'(1);
               end
            end
         end
         CLK_HI: begin
            if (cnt == HALF_LAST) begin
               sample  = 1'b1;
               cnt_n   = '0;
               state_n = CLK_LO;
            end
         end
         CLK_LO: begin
            if (cnt == HALF_LAST) begin
               cnt_n = '0;
               if (idx == IDX_LAST) begin
                  state_n = DONE;
               end else begin
                  idx_n   = idx + IW'(1);
                  state_n = CLK_HI;
               end
            end
         end
         DONE: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

   always_comb begin
      shift_n = shift_q;
      if (sample)
         for (int p = 0; p < NUM_PADS; p++)
            shift_n[p * BITS + int'(idx)] = sync2[p];
   end

   // Result registers load on entry to DONE so they line up with valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         idx      <= '0;
         shift_q  <= '1;
         buttons  <= '0;
         pressed  <= '0;
         released <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         shift_q <= shift_n;
         if (state_n == DONE) begin
            buttons  <= ~shift_n;
            pressed  <= ~shift_n & ~buttons;
            released <= shift_n & buttons;
         end
      end
   end

   assign nes_latch = (state == LATCH);
   assign nes_clock = (state == CLK_HI);
   assign valid     = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: doc/nes_controller_reader.md
# nes_controller_reader

Parametrised reader for one or more NES/SNES-style serial game pads sharing one latch and one shift-clock line. It generates the latch pulse and the shift-clock pulse train, and samples each pad's serial data line. It also publishes a debounced-per-frame button vector with pressed and released edge flags. It sits between the pad connector pins and game logic, and replaces the free-running latch generator.

## Interface
- CLK_HZ, 50000000: system clock frequency; documentation only, not used in arithmetic.
- NUM_PADS, 1: number of pads sharing latch and clock (1..4).
- BITS, 8: bits shifted per pad per frame (8 = NES, 16 = SNES).
- HALF_CYCLES, 300: clk cycles per half shift period (6 µs at 50 MHz); must be ≥ 4.
- POLL_CYCLES, 833333: clk cycles between automatic polls (60 Hz); must exceed frame length.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  when high, the automatic poll timer runs; when low, the timer is held at 0.
- poll_now  in  1  single-cycle request to start a frame immediately.
- nes_data  in  NUM_PADS  serial data from each pad; active-low (0 = pressed).
- nes_latch  out  1  latch pulse to all pads.
- nes_clock  out  1  shift clock to all pads; idles low.
- buttons  out  NUM_PADS*BITS  current state, 1 = pressed; pad p at [p*BITS +: BITS], bit 0 = first bit shifted (A).
- pressed  out  NUM_PADS*BITS  bits that went 0→1 this frame; valid with `valid`.
- released  out  NUM_PADS*BITS  bits that went 1→0 this frame; valid with `valid`.
- valid  out  1  one-cycle strobe when buttons/pressed/released update.
- busy  out  1  high from frame start to the `valid` cycle inclusive.

## Operation
- nes_data passes through a 2-flop synchronizer per pad; the synchronizer resets to all 1s (not pressed).
- Poll timer: counts 0..POLL_CYCLES-1 and wraps. It produces a tick on the cycle it holds POLL_CYCLES-1.
- Start condition = tick OR poll_now. A start that arrives while busy is dropped; it is not queued.
- FSM states:
  - IDLE: nes_latch=0, nes_clock=0. On start → LATCH; busy goes high the next cycle.
  - LATCH: nes_latch=1 for 2*HALF_CYCLES cycles. On the last cycle, sample the synchronized data of every pad into shift bit 0. Then → CLK_HI with bit index 1, or → DONE if BITS=1.
  - CLK_HI: nes_clock=1 for HALF_CYCLES cycles. On the last cycle, sample into bit[index]. Then → CLK_LO.
  - CLK_LO: nes_clock=0 for HALF_CYCLES cycles. Then, if index=BITS-1 → DONE; else increment index and → CLK_HI.
  - DONE: one cycle.
    - new = ~shift_reg (invert to active-high).
    - buttons ← new; pressed ← new & ~buttons; released ← ~new & buttons.
    - valid=1. Then → IDLE.
- Pulse counts: BITS-1 clock pulses per frame. All pads are sampled in the same cycle.
- pressed and released hold their value until the next DONE; consumers qualify them with `valid`.
- Deasserting enable mid-frame does not abort the frame. poll_now still works while enable=0.

## Timing
- Reset values: nes_latch=0, nes_clock=0, buttons=0, pressed=0, released=0, valid=0, busy=0. The FSM resets to IDLE and the poll timer to 0. Reset mid-frame returns all outputs to these values immediately (asynchronous).
- Frame length: from the first LATCH cycle to the DONE cycle is 2*HALF_CYCLES*BITS cycles. valid asserts in the cycle after that span. Defaults: 4800 cycles, 96 µs.
- Synchronizer latency is 2 cycles. Each sample therefore reflects the pin state ≥ HALF_CYCLES-2 cycles after the preceding nes_clock rising edge or latch rising edge.
- Start at cycle t → nes_latch high at t+1 (registered output).
- The bit counter is $clog2(BITS) wide; no wrap beyond BITS-1.

## Test plan
- Reset then idle. Hold rst_n=0, then release with enable=0 and no poll_now for 1000 cycles → every output stays 0 and nes_latch/nes_clock never toggle.
- Single NES frame. Parameters HALF_CYCLES=4, BITS=8, NUM_PADS=1. Pad model drives bit pattern A,Start pressed (active-low serial 0,1,1,0,1,1,1,1), then pulse poll_now → latch high 8 cycles, 7 clock pulses of 4 high/4 low, buttons=8'b0000_1001, pressed=8'b0000_1001, valid one cycle, 64 cycles from the first latch cycle.
- Edge flags. Second frame with only Start held → buttons=8'b0000_1000, pressed=0, released=8'b0000_0001.
- Multi-pad SNES. NUM_PADS=2, BITS=16. Pad0 all released, pad1 all pressed → buttons=32'hFFFF_0000, 15 clock pulses.
- Poll timer and drop. POLL_CYCLES=200, enable=1 → latch starts every 200 cycles. A poll_now pulse issued while busy causes no extra frame.
- Reset mid-frame. Assert rst_n=0 during CLK_HI → nes_clock, busy and buttons go to 0 within the same cycle. After release, the next poll runs a complete frame.
